// File: rtl/z80_incdec_rmw_unit_pkg.sv
// Shared definitions for the INC/DEC execution unit: F register bit positions
// and the memory-cycle codes used by the read-modify-write sequencer.
package z80_incdec_rmw_unit_pkg;

    localparam int FLAG_N_BIT = 1;
    localparam int FLAG_V_BIT = 2;
    localparam int FLAG_H_BIT = 4;
    localparam int FLAG_Z_BIT = 6;
    localparam int FLAG_S_BIT = 7;

    typedef enum logic [1:0] {
        MEM_CYC_NONE  = 2'd0,
        MEM_CYC_READ  = 2'd1,
        MEM_CYC_WRITE = 2'd2
    } mem_cycle_e;

endpackage

// File: rtl/z80_incdec_rmw_unit_alu.sv
// Combinational INC/DEC core: +/-1 modulo 2^DATA_W with Z80 flag rules.
// 16-bit INC/DEC rr leaves F untouched.
module z80_incdec_alu
    import z80_incdec_rmw_unit_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] operand,
    input  logic              dec,
    input  logic [7:0]        flags_in,
    output logic [DATA_W-1:0] result,
    output logic [7:0]        flags_out
);

    assign result = dec ? (operand - DATA_W'(1)) : (operand + DATA_W'(1));

    generate
        if (DATA_W == 8) begin : g_flags8
            // Bits 5, 3 and C pass through from the incoming F.
            always_comb begin
                flags_out             = flags_in;
                flags_out[FLAG_S_BIT] = result[7];
                flags_out[FLAG_Z_BIT] = (result == '0);
                flags_out[FLAG_H_BIT] = dec ? (operand[3:0] == 4'h0) : (operand[3:0] == 4'hF);
                flags_out[FLAG_V_BIT] = dec ? (operand == 8'h80) : (operand == 8'h7F);
                flags_out[FLAG_N_BIT] = dec;
            end
        end else begin : g_flags16
            assign flags_out = flags_in;
        end
    endgenerate

endmodule

// File: rtl/z80_incdec_rmw_unit.sv
// Sequenced INC/DEC unit covering r, rr and memory read-modify-write operands.
// Memory bytes move over a held req / single-cycle ack port, low byte first.
module z80_incdec_rmw_unit
    import z80_incdec_rmw_unit_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op_dec,
    input  logic              op_mem,
    input  logic [DATA_W-1:0] operand_in,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [7:0]        flags_in,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [7:0]        flags_out
);

    generate
        if (DATA_W != 8 && DATA_W != 16) begin : g_bad_width
            $error("z80_incdec_rmw_unit: DATA_W must be 8 or 16");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_CALC  = 3'd3,
        ST_WR_LO = 3'd4,
        ST_WR_HI = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    localparam bit WIDE = (DATA_W == 16);

    state_e            state_q, state_d;
    logic              dec_q, dec_d;
    logic              mem_op_q, mem_op_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [7:0]        fin_q, fin_d;
    logic [7:0]        flags_out_q, flags_out_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic [DATA_W-1:0] alu_result;
    logic [7:0]        alu_flags;
    logic [15:0]       result_ext;
    mem_cycle_e        mem_cycle;

    z80_incdec_alu #(.DATA_W(DATA_W)) u_alu (
        .operand   (operand_q),
        .dec       (dec_q),
        .flags_in  (fin_q),
        .result    (alu_result),
        .flags_out (alu_flags)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dec_q       <= 1'b0;
            mem_op_q    <= 1'b0;
            operand_q   <= '0;
            result_q    <= '0;
            fin_q       <= '0;
            flags_out_q <= '0;
            base_q      <= '0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            mem_op_q    <= mem_op_d;
            operand_q   <= operand_d;
            result_q    <= result_d;
            fin_q       <= fin_d;
            flags_out_q <= flags_out_d;
            base_q      <= base_d;
        end
    end

    // Operand bytes assemble low-then-high; result and F commit only in CALC.
    always_comb begin
        state_d     = state_q;
        dec_d       = dec_q;
        mem_op_d    = mem_op_q;
        operand_d   = operand_q;
        result_d    = result_q;
        fin_d       = fin_q;
        flags_out_d = flags_out_q;
        base_d      = base_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dec_d    = op_dec;
                    mem_op_d = op_mem;
                    fin_d    = flags_in;
                    base_d   = addr_in;
                    if (op_mem) begin
                        state_d = ST_RD_LO;
                    end else begin
                        operand_d = operand_in;
                        state_d   = ST_CALC;
                    end
                end
            end
            ST_RD_LO: begin
                if (mem_ack) begin
                    operand_d = DATA_W'(mem_rdata);
                    state_d   = WIDE ? ST_RD_HI : ST_CALC;
                end
            end
            ST_RD_HI: begin
                if (mem_ack) begin
                    operand_d = DATA_W'({mem_rdata, operand_q[7:0]});
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                result_d    = alu_result;
                flags_out_d = alu_flags;
                state_d     = mem_op_q ? ST_WR_LO : ST_DONE;
            end
            ST_WR_LO: begin
                if (mem_ack) begin
                    state_d = WIDE ? ST_WR_HI : ST_DONE;
                end
            end
            ST_WR_HI: begin
                if (mem_ack) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_cycle = MEM_CYC_NONE;
        case (state_q)
            ST_RD_LO, ST_RD_HI: mem_cycle = MEM_CYC_READ;
            ST_WR_LO, ST_WR_HI: mem_cycle = MEM_CYC_WRITE;
            default:            mem_cycle = MEM_CYC_NONE;
        endcase
    end

    assign result_ext = 16'(result_q);

    assign mem_rd_req = (mem_cycle == MEM_CYC_READ);
    assign mem_wr_req = (mem_cycle == MEM_CYC_WRITE);
    // High byte lives at base+1, wrapping at the top of the address space.
    assign mem_addr   = (state_q == ST_RD_HI || state_q == ST_WR_HI) ? (base_q + ADDR_W'(1)) : base_q;
    assign mem_wdata  = (state_q == ST_WR_HI) ? result_ext[15:8] : result_ext[7:0];
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign result     = result_q;
    assign flags_out  = flags_out_q;

endmodule

// File: tb/tb_z80_incdec_rmw_unit.sv
// Randomised bench for the INC/DEC unit: an 8-bit and a 16-bit instance share
// a byte-array memory model and are checked against arithmetic expectations.
module tb_z80_incdec_rmw_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic        op_dec = 1'b0, op_mem = 1'b0;
    logic [7:0]  operand8 = '0;
    logic [15:0] operand16 = '0;
    logic [15:0] addr_in = '0;
    logic [7:0]  flags_in = '0;
    logic [7:0]  mem_rdata = '0;
    logic        mem_ack = 1'b0;

    logic        rd8, wr8, busy8, done8;
    logic [15:0] addr8;
    logic [7:0]  wdata8, res8, flags8;
    logic        rd16, wr16, busy16, done16;
    logic [15:0] addr16, res16;
    logic [7:0]  wdata16, flags16;

    logic        wide_sel = 1'b0;
    logic        cur_rd, cur_wr, cur_busy, cur_done;
    logic [15:0] cur_addr, cur_res;
    logic [7:0]  cur_wdata, cur_flags;

    logic [7:0]  mem [0:65535];
    int          compared = 0;
    int          mismatched = 0;
    int          op_num = 0;

    always #5 clk = ~clk;

    z80_incdec_rmw_unit #(.DATA_W(8), .ADDR_W(16)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op_dec(op_dec), .op_mem(op_mem),
        .operand_in(operand8), .addr_in(addr_in), .flags_in(flags_in),
        .mem_rd_req(rd8), .mem_wr_req(wr8), .mem_addr(addr8), .mem_wdata(wdata8),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy8), .done(done8),
        .result(res8), .flags_out(flags8)
    );

    z80_incdec_rmw_unit #(.DATA_W(16), .ADDR_W(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .op_dec(op_dec), .op_mem(op_mem),
        .operand_in(operand16), .addr_in(addr_in), .flags_in(flags_in),
        .mem_rd_req(rd16), .mem_wr_req(wr16), .mem_addr(addr16), .mem_wdata(wdata16),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy16), .done(done16),
        .result(res16), .flags_out(flags16)
    );

    assign cur_rd    = wide_sel ? rd16 : rd8;
    assign cur_wr    = wide_sel ? wr16 : wr8;
    assign cur_busy  = wide_sel ? busy16 : busy8;
    assign cur_done  = wide_sel ? done16 : done8;
    assign cur_addr  = wide_sel ? addr16 : addr8;
    assign cur_wdata = wide_sel ? wdata16 : wdata8;
    assign cur_res   = wide_sel ? res16 : {8'h00, res8};
    assign cur_flags = wide_sel ? flags16 : flags8;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] modelFlags8(input int opv, input int res, input bit dec, input logic [7:0] fin);
        bit s, z, h, v;
        s = (res >= 128);
        z = (res == 0);
        h = dec ? ((opv % 16) == 0) : ((opv % 16) == 15);
        v = dec ? (opv == 128) : (opv == 127);
        return {s, z, fin[5], h, fin[3], v, dec, fin[0]};
    endfunction

    // Runs one operation end to end, playing the memory side and scoring it.
    task automatic applyStimulus(input bit wide, input bit dec, input bit mem_op,
                                 input logic [15:0] opnd, input logic [15:0] addr,
                                 input logic [7:0] fin, input int min_wait, input int max_wait,
                                 input bit hold, output logic [15:0] act_res, output logic [7:0] act_flags);
        logic [15:0] ahi;
        int          val, modulus, exp_res, exp_cycles, cycles, waits, wait_target, total_waits;
        logic [7:0]  exp_flags;
        logic [15:0] rd_q[$];
        logic [15:0] wa_q[$];
        logic [7:0]  wd_q[$];
        bit          both_req;

        op_num++;
        ahi     = addr + 16'd1;
        modulus = wide ? 65536 : 256;
        if (mem_op) val = wide ? int'({mem[ahi], mem[addr]}) : int'(mem[addr]);
        else        val = wide ? int'(opnd) : int'(opnd[7:0]);
        exp_res   = (val + (dec ? -1 : 1) + modulus) % modulus;
        exp_flags = wide ? fin : modelFlags8(val, exp_res, dec, fin);

        wide_sel = wide;
        @(negedge clk);
        op_dec    = dec;
        op_mem    = mem_op;
        addr_in   = addr;
        flags_in  = fin;
        operand8  = opnd[7:0];
        operand16 = opnd;
        start8    = !wide;
        start16   = wide;
        @(negedge clk);
        if (!hold) begin
            start8  = 1'b0;
            start16 = 1'b0;
        end
        cycles      = 1;
        waits       = 0;
        total_waits = 0;
        both_req    = 1'b0;
        wait_target = $urandom_range(max_wait, min_wait);
        while (!cur_done && cycles < 100) begin
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            if (cur_rd && cur_wr) both_req = 1'b1;
            if (cur_rd || cur_wr) begin
                if (waits < wait_target) begin
                    waits++;
                    total_waits++;
                end else begin
                    mem_ack = 1'b1;
                    if (cur_rd) begin
                        rd_q.push_back(cur_addr);
                        mem_rdata = mem[cur_addr];
                    end else begin
                        wa_q.push_back(cur_addr);
                        wd_q.push_back(cur_wdata);
                        mem[cur_addr] = cur_wdata;
                    end
                    waits       = 0;
                    wait_target = $urandom_range(max_wait, min_wait);
                end
            end
            @(negedge clk);
            cycles++;
        end
        mem_ack = 1'b0;
        start8  = 1'b0;
        start16 = 1'b0;

        exp_cycles = (mem_op ? (wide ? 6 : 4) : 2) + total_waits;
        checkOutput($sformatf("op%0d done_seen", op_num), 32'(cur_done), 32'd1);
        checkOutput($sformatf("op%0d latency", op_num), 32'(cycles), 32'(exp_cycles));
        checkOutput($sformatf("op%0d result", op_num), 32'(cur_res), 32'(exp_res));
        checkOutput($sformatf("op%0d flags", op_num), 32'(cur_flags), 32'(exp_flags));
        checkOutput($sformatf("op%0d req_exclusive", op_num), 32'(both_req), 32'd0);
        act_res   = cur_res;
        act_flags = cur_flags;

        if (mem_op) begin
            checkOutput($sformatf("op%0d n_reads", op_num), 32'(rd_q.size()), wide ? 32'd2 : 32'd1);
            checkOutput($sformatf("op%0d n_writes", op_num), 32'(wa_q.size()), wide ? 32'd2 : 32'd1);
            if (rd_q.size() > 0) checkOutput($sformatf("op%0d rd_addr_lo", op_num), 32'(rd_q[0]), 32'(addr));
            if (wa_q.size() > 0) begin
                checkOutput($sformatf("op%0d wr_addr_lo", op_num), 32'(wa_q[0]), 32'(addr));
                checkOutput($sformatf("op%0d wr_data_lo", op_num), 32'(wd_q[0]), 32'(exp_res % 256));
            end
            if (wide && rd_q.size() > 1) checkOutput($sformatf("op%0d rd_addr_hi", op_num), 32'(rd_q[1]), 32'(ahi));
            if (wide && wa_q.size() > 1) begin
                checkOutput($sformatf("op%0d wr_addr_hi", op_num), 32'(wa_q[1]), 32'(ahi));
                checkOutput($sformatf("op%0d wr_data_hi", op_num), 32'(wd_q[1]), 32'(exp_res / 256));
            end
        end

        @(negedge clk);
        checkOutput($sformatf("op%0d done_once", op_num), 32'(cur_done), 32'd0);
        checkOutput($sformatf("op%0d idle_after", op_num), 32'(cur_busy), 32'd0);
    endtask

    initial begin
        logic [15:0] o, a, ahi, r;
        logic [7:0]  fin, f;
        bit          w, d, m, h;
        int          guard;
        bit          done_seen;

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("reset8 ctrl", 32'({busy8, done8, rd8, wr8}), 32'd0);
        checkOutput("reset8 addr", 32'(addr8), 32'd0);
        checkOutput("reset8 wdata", 32'(wdata8), 32'd0);
        checkOutput("reset8 result", 32'(res8), 32'd0);
        checkOutput("reset8 flags", 32'(flags8), 32'd0);
        checkOutput("reset16 ctrl", 32'({busy16, done16, rd16, wr16}), 32'd0);
        checkOutput("reset16 result", 32'(res16), 32'd0);

        $display("[TB] directed register cases");
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h007F, 16'h0000, 8'h00, 0, 0, 1'b0, r, f);
        checkOutput("inc7F result", 32'(r), 32'h80);
        checkOutput("inc7F flags", 32'(f), 32'h94);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 8'h29, 0, 0, 1'b0, r, f);
        checkOutput("dec00 result", 32'(r), 32'hFF);
        checkOutput("dec00 flags", 32'(f), 32'hBB);
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h00FF, 16'h0000, 8'h00, 0, 0, 1'b1, r, f);
        checkOutput("incFF_held result", 32'(r), 32'h00);

        $display("[TB] directed memory cases");
        mem[16'h1234] = 8'h01;
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 16'h1234, 8'h00, 2, 2, 1'b0, r, f);
        checkOutput("memdec byte", 32'(mem[16'h1234]), 32'h00);
        checkOutput("memdec ZN", 32'(f & 8'h42), 32'h42);
        mem[16'hFFFF] = 8'hFF;
        mem[16'h0000] = 8'h00;
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 8'hD7, 0, 0, 1'b0, r, f);
        checkOutput("wrap lo byte", 32'(mem[16'hFFFF]), 32'h00);
        checkOutput("wrap hi byte", 32'(mem[16'h0000]), 32'h01);
        checkOutput("wrap flags", 32'(f), 32'hD7);

        $display("[TB] reset during write, start held");
        wide_sel = 1'b0;
        mem[16'h4000] = 8'h55;
        @(negedge clk);
        start8   = 1'b1;
        op_mem   = 1'b1;
        op_dec   = 1'b0;
        addr_in  = 16'h4000;
        flags_in = 8'hFF;
        @(negedge clk);
        guard     = 0;
        done_seen = 1'b0;
        while (!wr8 && guard < 20) begin
            mem_ack   = rd8;
            mem_rdata = mem[addr8];
            @(negedge clk);
            done_seen = done_seen | done8;
            guard++;
        end
        mem_ack = 1'b0;
        checkOutput("rst reached WR_LO", 32'(wr8), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        start8 = 1'b0;
        checkOutput("rst ctrl", 32'({busy8, done8, rd8, wr8}), 32'd0);
        checkOutput("rst addr", 32'(addr8), 32'd0);
        checkOutput("rst wdata", 32'(wdata8), 32'd0);
        checkOutput("rst result", 32'(res8), 32'd0);
        checkOutput("rst flags", 32'(flags8), 32'd0);
        checkOutput("rst no done", 32'(done_seen), 32'd0);
        checkOutput("rst mem untouched", 32'(mem[16'h4000]), 32'h55);
        @(negedge clk);
        checkOutput("rst stays idle", 32'(busy8), 32'd0);

        $display("[TB] randomised operations");
        for (int i = 0; i < 48; i++) begin
            w   = 1'($urandom_range(1, 0));
            d   = 1'($urandom_range(1, 0));
            m   = 1'($urandom_range(1, 0));
            h   = ($urandom_range(3, 0) == 0);
            o   = 16'($urandom);
            a   = ($urandom_range(7, 0) == 0) ? 16'hFFFF : 16'($urandom);
            fin = 8'($urandom);
            case ($urandom_range(6, 0))
                0: o = 16'hFFFF;
                1: o = 16'h0000;
                2: o = 16'h007F;
                3: o = 16'h0080;
                default: ;
            endcase
            if (!w) o[15:8] = 8'h00;
            if (m) begin
                ahi      = a + 16'd1;
                mem[a]   = o[7:0];
                mem[ahi] = o[15:8];
            end
            applyStimulus(w, d, m, o, a, fin, 0, 3, h, r, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
